// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU core, its instruction ROM and the program loader.
package cpu_pkg;

    // Instruction memory geometry (8-bit PC, byte-wide words)
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Frame start marker on the host byte stream
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader frame-parsing states
    typedef enum logic [2:0] {
        LD_IDLE,
        LD_ADDR,
        LD_LEN,
        LD_DATA,
        LD_CSUM,
        LD_CHECK
    } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/START/LEN/payload/CSUM frames,
// writes the payload into instruction memory and keeps the CPU held in reset
// until a frame with a good checksum has been loaded.
module prog_loader #(
    parameter int         ADDR_W    = cpu_pkg::ADDR_W,
    parameter int         DATA_W    = cpu_pkg::DATA_W,
    parameter logic [7:0] SYNC_BYTE = cpu_pkg::SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    import cpu_pkg::*;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    // The only non-accepting cycle is the single checksum-evaluation cycle
    assign in_ready = (state_q != LD_CHECK);
    assign accept   = in_valid && in_ready;

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

    // Next-state, datapath and output computation for the frame parser
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;

        unique case (state_q)
            LD_IDLE: begin
                // Anything other than SYNC is line noise and is dropped
                if (accept && in_data == SYNC_BYTE) begin
                    state_d    = LD_ADDR;
                    sum_d      = 8'h00;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            LD_ADDR: begin
                if (accept) begin
                    ptr_d   = ADDR_W'(in_data);
                    sum_d   = in_data;
                    state_d = LD_LEN;
                end
            end
            LD_LEN: begin
                if (accept) begin
                    cnt_d   = in_data;
                    sum_d   = sum_q + in_data;
                    state_d = (in_data != 8'h00) ? LD_DATA : LD_CSUM;
                end
            end
            LD_DATA: begin
                // Payload bytes are never reinterpreted as SYNC
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = DATA_W'(in_data);
                    ptr_d       = ptr_q + ADDR_W'(1);
                    sum_d       = sum_q + in_data;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = LD_CSUM;
                end
            end
            LD_CSUM: begin
                if (accept) begin
                    sum_d   = sum_q + in_data;
                    state_d = LD_CHECK;
                end
            end
            LD_CHECK: begin
                if (sum_q == 8'h00) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = LD_IDLE;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // State and output registers; reset keeps the CPU held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LD_IDLE;
            ptr_q       <= '0;
            cnt_q       <= 8'h00;
            sum_q       <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
